// File: rtl/jpeg_block_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_block_pkg
//  Description : Shared block geometry, zigzag scan table and bank-state
//                encoding for the JPEG block ping-pong buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpeg_block_pkg;

   localparam int BLOCK_DIM  = 8;
   localparam int BLOCK_SIZE = 64;

   // Bank occupancy; FULL banks are never written or aborted.
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_e;

   // Output index k -> raster index (row*8 + col) of the standard JPEG scan.
   localparam logic [5:0] ZIGZAG_LUT [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage
`default_nettype wire

// File: rtl/zigzag_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_pingpong_buffer_if
//  Description : Row-input and block-output handshake bundle of the
//                ping-pong block buffer. master = producer/consumer side,
//                slave = buffer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zigzag_pingpong_buffer_if #(
   parameter int DATA_WIDTH = 10
) ();

   logic                       in_valid;
   logic                       in_ready;
   logic [8*DATA_WIDTH-1:0]    in_row_data;
   logic                       in_abort;
   logic [2:0]                 wr_row;
   logic                       out_valid;
   logic                       out_ready;
   logic [64*DATA_WIDTH-1:0]   out_block;
   logic [5:0]                 out_last_nz;
   logic                       out_all_zero;

   modport master (
      output in_valid, in_row_data, in_abort, out_ready,
      input  in_ready, wr_row, out_valid, out_block, out_last_nz, out_all_zero
   );

   modport slave (
      input  in_valid, in_row_data, in_abort, out_ready,
      output in_ready, wr_row, out_valid, out_block, out_last_nz, out_all_zero
   );

endinterface
`default_nettype wire

// File: rtl/zigzag_permute_comb.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_permute_comb
//  Description : Pure wiring permutation of a 64-coefficient block from
//                raster order into zigzag (OUT_ORDER=0) or raster
//                (OUT_ORDER=1) output order.
//  Revision    : 1.0 - initial release
// ============================================================================
module zigzag_permute_comb
   import jpeg_block_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int OUT_ORDER  = 0
) (
   input  wire logic [BLOCK_SIZE*DATA_WIDTH-1:0] i_block,
   output logic      [BLOCK_SIZE*DATA_WIDTH-1:0] o_block
);

   for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_perm
      if (OUT_ORDER == 0) begin : g_zigzag
         assign o_block[k*DATA_WIDTH +: DATA_WIDTH] =
            i_block[int'(ZIGZAG_LUT[k])*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_raster
         assign o_block[k*DATA_WIDTH +: DATA_WIDTH] =
            i_block[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule
`default_nettype wire

// File: rtl/zigzag_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_pingpong_buffer
//  Description : Two-bank ping-pong 8x8 coefficient buffer. Rows enter under
//                valid/ready; each completed block is presented as one wide
//                word in zigzag or raster order until the consumer takes it.
//                Optional end-of-block detection: ZIGZAG_EOB_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module zigzag_pingpong_buffer
   import jpeg_block_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int OUT_ORDER  = 0
) (
   input  wire logic                 clock,
   input  wire logic                 reset,
   zigzag_pingpong_buffer_if.slave   bus
);

   localparam int c_ROW_W = BLOCK_DIM * DATA_WIDTH;

   logic [c_ROW_W-1:0]                r_bank [0:1][0:BLOCK_DIM-1];
   bank_state_e                       r_state [0:1];
   bank_state_e                       w_state_nxt [0:1];
   logic                              r_wr_bank, w_wr_bank_nxt;
   logic                              r_rd_bank, w_rd_bank_nxt;
   logic [2:0]                        r_wr_row,  w_wr_row_nxt;

   logic                              w_in_ready;
   logic                              w_out_valid;
   logic                              w_abort;
   logic                              w_accept;
   logic                              w_drain;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0]  w_rd_block;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0]  w_out_block;

   assign w_in_ready  = (r_state[r_wr_bank] != FULL);
   assign w_out_valid = (r_state[r_rd_bank] == FULL);
   // Abort only bites on a partially written bank, and then blocks the row.
   assign w_abort     = bus.in_abort && (r_state[r_wr_bank] == FILLING);
   assign w_accept    = bus.in_valid && w_in_ready && !w_abort;
   assign w_drain     = w_out_valid && bus.out_ready;

   // Bank-state, pointer and row-counter next-state logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_wr_bank_nxt = r_wr_bank;
      w_rd_bank_nxt = r_rd_bank;
      w_wr_row_nxt  = r_wr_row;
      // The drained bank is always FULL, so it never collides with the
      // write-side update below.
      if (w_drain) begin
         w_state_nxt[r_rd_bank] = EMPTY;
         w_rd_bank_nxt          = ~r_rd_bank;
      end
      if (w_abort) begin
         w_state_nxt[r_wr_bank] = EMPTY;
         w_wr_row_nxt           = 3'd0;
      end else if (w_accept) begin
         w_wr_row_nxt = r_wr_row + 3'd1;
         if (r_wr_row == 3'd7) begin
            w_state_nxt[r_wr_bank] = FULL;
            w_wr_bank_nxt          = ~r_wr_bank;
         end else begin
            w_state_nxt[r_wr_bank] = FILLING;
         end
      end
   end

   // State register: bank states, pointers and row counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state[0] <= EMPTY;
         r_state[1] <= EMPTY;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_wr_row   <= 3'd0;
      end else begin
         r_state[0] <= w_state_nxt[0];
         r_state[1] <= w_state_nxt[1];
         r_wr_bank  <= w_wr_bank_nxt;
         r_rd_bank  <= w_rd_bank_nxt;
         r_wr_row   <= w_wr_row_nxt;
      end
   end

   // Row storage; cleared on reset so an idle output reads all zeros.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < BLOCK_DIM; r++) begin
               r_bank[b][r] <= '0;
            end
         end
      end else if (w_accept) begin
         r_bank[r_wr_bank][r_wr_row] <= bus.in_row_data;
      end
   end

   // Read-bank mux flattened into one raster-ordered block.
   for (genvar r = 0; r < BLOCK_DIM; r++) begin : g_rd_rows
      assign w_rd_block[r*c_ROW_W +: c_ROW_W] = r_bank[r_rd_bank][r];
   end

   zigzag_permute_comb #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_ORDER  (OUT_ORDER)
   ) u_permute (
      .i_block (w_rd_block),
      .o_block (w_out_block)
   );

   assign bus.in_ready  = w_in_ready;
   assign bus.wr_row    = r_wr_row;
   assign bus.out_valid = w_out_valid;
   assign bus.out_block = w_out_block;

`ifdef ZIGZAG_EOB_DETECT_EN
   logic [5:0] w_last_nz;
   logic       w_all_zero;

   // Highest nonzero output index and all-zero flag of the presented block.
   always_comb begin
      w_last_nz  = 6'd0;
      w_all_zero = 1'b1;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
         if (w_out_block[k*DATA_WIDTH +: DATA_WIDTH] != '0) begin
            w_last_nz  = 6'(k);
            w_all_zero = 1'b0;
         end
      end
   end

   assign bus.out_last_nz  = w_last_nz;
   assign bus.out_all_zero = w_all_zero;
`else
   assign bus.out_last_nz  = 6'd0;
   assign bus.out_all_zero = 1'b0;
`endif

   // The read pointer may only differ from the write pointer while it sits
   // on a FULL bank; anything else means the ping-pong order broke.
   a_ptr_consistent : assert property (@(posedge clock) disable iff (reset)
      !((r_rd_bank != r_wr_bank) && (r_state[r_rd_bank] != FULL)));

endmodule
`default_nettype wire
